// File: rtl/pipe_scoreboard.sv
// pipe_scoreboard
//   Interlock and forwarding controller for an in-order MIPS pipeline.
//   Every in-flight GPR write is tracked in a per-stage slot, so hazards
//   are found without re-decoding the later stages. The block produces the
//   decode stall, the D/E bubble and the D- and E-stage forward selects.
//   It also owns the multiply/divide busy counter that interlocks HI/LO users.
//
// Ports
//   clk, rst_n             clock, synchronous active-low reset
//   d_valid                D holds a real instruction
//   d_rs/d_rt              source registers
//   d_*_use, d_*_late      source is read / is needed in E (1) or in D (0)
//   d_wr, d_wa, d_rdy      destination write, address, first slot holding result
//   d_md_start, d_md_div   D starts a mult/div (div selects DIV_LAT)
//   d_md_use               D touches HI/LO or starts an md op
//   flush                  kill the instruction in D
//   stall, bubble_e        hold F/D and PC / insert a nop into D/E
//   fwd_r*_d, fwd_r*_e     operand source: 0 = normal path, k = slot k
//   md_busy                md unit still working
module pipe_scoreboard #(
  parameter int NSTAGE   = 3,
  parameter int AW       = 5,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  localparam int FW      = $clog2(NSTAGE + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          d_valid,
  input  logic [AW-1:0] d_rs,
  input  logic [AW-1:0] d_rt,
  input  logic          d_rs_use,
  input  logic          d_rt_use,
  input  logic          d_rs_late,
  input  logic          d_rt_late,
  input  logic          d_wr,
  input  logic [AW-1:0] d_wa,
  input  logic [FW-1:0] d_rdy,
  input  logic          d_md_start,
  input  logic          d_md_div,
  input  logic          d_md_use,
  input  logic          flush,
  output logic          stall,
  output logic          bubble_e,
  output logic [FW-1:0] fwd_rs_d,
  output logic [FW-1:0] fwd_rt_d,
  output logic [FW-1:0] fwd_rs_e,
  output logic [FW-1:0] fwd_rt_e,
  output logic          md_busy
);

  localparam int MD_MAX = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int MDW    = $clog2(MD_MAX + 1);

  // Slot k holds the write of the instruction k stages past D.
  logic          r_v   [1:NSTAGE];
  logic [AW-1:0] r_wa  [1:NSTAGE];
  logic [FW-1:0] r_rdy [1:NSTAGE];

  // Sources of the instruction currently in E (slot 1).
  logic [AW-1:0] r_e_rs;
  logic [AW-1:0] r_e_rt;
  logic          r_e_rs_use;
  logic          r_e_rt_use;

  logic [MDW-1:0] r_md_cnt;

  logic          w_rs_hz;
  logic          w_rt_hz;
  logic          w_md_busy;
  logic          w_issue;
  logic [FW-1:0] w_fwd_rs_d;
  logic [FW-1:0] w_fwd_rt_d;
  logic [FW-1:0] w_fwd_rs_e;
  logic [FW-1:0] w_fwd_rt_e;

  // D-stage hazard and forward. The walk runs oldest to youngest so the
  // youngest matching slot is the last to write the result.
  always_comb begin
    // NOTE: every variable gets a default first, so no latch is inferred.
    w_rs_hz    = 1'b0;
    w_rt_hz    = 1'b0;
    w_fwd_rs_d = '0;
    w_fwd_rt_d = '0;
    for (int k = NSTAGE; k >= 1; k--) begin
      if (d_valid && d_rs_use && r_v[k] && (r_wa[k] == d_rs)) begin
        // A late operand can also take the value from slot k+1 next cycle.
        w_rs_hz    = d_rs_late ? (int'(r_rdy[k]) > k + 1) : (int'(r_rdy[k]) > k);
        w_fwd_rs_d = d_rs_late ? '0 : FW'(k);
      end
      if (d_valid && d_rt_use && r_v[k] && (r_wa[k] == d_rt)) begin
        w_rt_hz    = d_rt_late ? (int'(r_rdy[k]) > k + 1) : (int'(r_rdy[k]) > k);
        w_fwd_rt_d = d_rt_late ? '0 : FW'(k);
      end
    end
  end

  // E-stage forward: issue-time interlock guarantees the producer is ready.
  always_comb begin
    w_fwd_rs_e = '0;
    w_fwd_rt_e = '0;
    for (int k = NSTAGE; k >= 2; k--) begin
      if (r_e_rs_use && r_v[k] && (r_wa[k] == r_e_rs)) w_fwd_rs_e = FW'(k);
      if (r_e_rt_use && r_v[k] && (r_wa[k] == r_e_rt)) w_fwd_rt_e = FW'(k);
    end
  end

  assign w_md_busy = (r_md_cnt != '0);
  // flush dominates: a killed instruction never stalls and never issues.
  assign stall     = d_valid && !flush && (w_rs_hz || w_rt_hz || (d_md_use && w_md_busy));
  assign bubble_e  = stall || flush;
  assign w_issue   = d_valid && !flush && !stall;

  assign fwd_rs_d  = w_fwd_rs_d;
  assign fwd_rt_d  = w_fwd_rt_d;
  assign fwd_rs_e  = w_fwd_rs_e;
  assign fwd_rt_e  = w_fwd_rt_e;
  assign md_busy   = w_md_busy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the slot array is control state, so every entry is reset,
      // not just the valid bits; the compare logic never sees X.
      for (int k = 1; k <= NSTAGE; k++) begin
        r_v[k]   <= 1'b0;
        r_wa[k]  <= '0;
        r_rdy[k] <= '0;
      end
      r_e_rs     <= '0;
      r_e_rt     <= '0;
      r_e_rs_use <= 1'b0;
      r_e_rt_use <= 1'b0;
      r_md_cnt   <= '0;
    end else begin
      // NOTE: non-blocking assignment lets each slot take its neighbour's
      // pre-edge value regardless of loop order.
      for (int k = NSTAGE; k >= 2; k--) begin
        r_v[k]   <= r_v[k-1];
        r_wa[k]  <= r_wa[k-1];
        r_rdy[k] <= r_rdy[k-1];
      end
      // Writes to $0 are dropped here so $0 can never match later.
      r_v[1]     <= w_issue && d_wr && (d_wa != '0);
      r_wa[1]    <= d_wa;
      r_rdy[1]   <= d_rdy;
      r_e_rs     <= d_rs;
      r_e_rt     <= d_rt;
      r_e_rs_use <= w_issue && d_rs_use;
      r_e_rt_use <= w_issue && d_rt_use;

      if (w_issue && d_md_start) begin
        r_md_cnt <= d_md_div ? MDW'(DIV_LAT) : MDW'(MULT_LAT);
      end else if (w_md_busy) begin
        r_md_cnt <= r_md_cnt - MDW'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Testbench for pipe_scoreboard. The reference model tracks in-flight
// writes as a list of {age, wa, rdy} records (age = cycles since issue)
// and the md unit as a "free at cycle" number. The driver pushes expected
// outputs into a queue; a monitor on the falling edge pops and compares.
module tb_pipe_scoreboard;

  localparam int NSTAGE   = 3;
  localparam int AW       = 5;
  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;
  localparam int FW       = 2;

  typedef struct {
    logic          valid;
    logic [AW-1:0] rs, rt;
    logic          rs_use, rt_use, rs_late, rt_late;
    logic          wr;
    logic [AW-1:0] wa;
    logic [FW-1:0] rdy;
    logic          md_start, md_div, md_use;
  } instr_t;

  typedef struct {
    int            cyc;
    string         tag;
    logic          stall, bubble, md_busy;
    logic [FW-1:0] frs_d, frt_d, frs_e, frt_e;
    logic          care_rs_d, care_rt_d;
  } exp_t;

  typedef struct {
    int            age;
    logic [AW-1:0] wa;
    int            rdy;
  } wr_t;

  logic          clk;
  logic          rst_n;
  logic          d_valid;
  logic [AW-1:0] d_rs, d_rt, d_wa;
  logic          d_rs_use, d_rt_use, d_rs_late, d_rt_late, d_wr;
  logic [FW-1:0] d_rdy;
  logic          d_md_start, d_md_div, d_md_use, flush;
  logic          stall, bubble_e, md_busy;
  logic [FW-1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;

  int errors = 0;
  int checks = 0;

  exp_t sb_q[$];

  // Reference model state.
  wr_t           fl[$];
  logic [AW-1:0] e_rs, e_rt;
  logic          e_rs_use = 1'b0;
  logic          e_rt_use = 1'b0;
  int            md_free_at = 0;
  int            cyc = 0;

  pipe_scoreboard #(
    .NSTAGE(NSTAGE), .AW(AW), .MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .d_valid(d_valid),
    .d_rs(d_rs), .d_rt(d_rt), .d_rs_use(d_rs_use), .d_rt_use(d_rt_use),
    .d_rs_late(d_rs_late), .d_rt_late(d_rt_late),
    .d_wr(d_wr), .d_wa(d_wa), .d_rdy(d_rdy),
    .d_md_start(d_md_start), .d_md_div(d_md_div), .d_md_use(d_md_use),
    .flush(flush), .stall(stall), .bubble_e(bubble_e),
    .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
    .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e), .md_busy(md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input string what, input int c,
                       input logic [1:0] got, input logic [1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s.%s cyc=%0d got=%0d required=%0d", tag, what, c, got, exp);
    end
  endtask

  // Monitor: the DUT presents a full set of outputs every cycle.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check(e.tag, "stall",    e.cyc, {1'b0, stall},    {1'b0, e.stall});
      check(e.tag, "bubble_e", e.cyc, {1'b0, bubble_e}, {1'b0, e.bubble});
      check(e.tag, "md_busy",  e.cyc, {1'b0, md_busy},  {1'b0, e.md_busy});
      check(e.tag, "fwd_rs_e", e.cyc, fwd_rs_e, e.frs_e);
      check(e.tag, "fwd_rt_e", e.cyc, fwd_rt_e, e.frt_e);
      if (e.care_rs_d) check(e.tag, "fwd_rs_d", e.cyc, fwd_rs_d, e.frs_d);
      if (e.care_rt_d) check(e.tag, "fwd_rt_d", e.cyc, fwd_rt_d, e.frt_d);
    end
  end

  // Youngest in-flight writer of r that is at least min_age stages old.
  function automatic bit youngest(input logic [AW-1:0] r, input int min_age,
                                  output int age, output int rdy);
    bit found = 1'b0;
    age = 0;
    rdy = 0;
    foreach (fl[i]) begin
      if (fl[i].wa == r && fl[i].age >= min_age && (!found || fl[i].age < age)) begin
        found = 1'b1;
        age   = fl[i].age;
        rdy   = fl[i].rdy;
      end
    end
    return found;
  endfunction

  // A value is usable in D once its age reaches rdy; a late operand
  // gets one more cycle because it is consumed in E.
  task automatic src_eval(input logic valid, input logic use_, input logic late,
                          input logic [AW-1:0] src, output logic hz,
                          output logic [FW-1:0] fwd, output logic care);
    int age, rdy;
    hz  = 1'b0;
    fwd = '0;
    if (valid && use_ && youngest(src, 1, age, rdy)) begin
      hz  = late ? (age + 1 < rdy) : (age < rdy);
      fwd = late ? '0 : FW'(age);
    end
    care = !(use_ && late) && !hz;
  endtask

  task automatic step(input instr_t in, input logic fls, input logic rst_v,
                      input string tag, output logic stalled);
    exp_t e;
    logic hz_rs, hz_rt, busy, issue;
    int   age, rdy;
    wr_t  nq[$];
    rst_n      = rst_v;
    d_valid    = in.valid;
    d_rs       = in.rs;
    d_rt       = in.rt;
    d_rs_use   = in.rs_use;
    d_rt_use   = in.rt_use;
    d_rs_late  = in.rs_late;
    d_rt_late  = in.rt_late;
    d_wr       = in.wr;
    d_wa       = in.wa;
    d_rdy      = in.rdy;
    d_md_start = in.md_start;
    d_md_div   = in.md_div;
    d_md_use   = in.md_use;
    flush      = fls;

    src_eval(in.valid, in.rs_use, in.rs_late, in.rs, hz_rs, e.frs_d, e.care_rs_d);
    src_eval(in.valid, in.rt_use, in.rt_late, in.rt, hz_rt, e.frt_d, e.care_rt_d);
    e.frs_e = '0;
    e.frt_e = '0;
    if (e_rs_use && youngest(e_rs, 2, age, rdy)) e.frs_e = FW'(age);
    if (e_rt_use && youngest(e_rt, 2, age, rdy)) e.frt_e = FW'(age);
    busy      = cyc < md_free_at;
    e.stall   = in.valid && !fls && (hz_rs || hz_rt || (in.md_use && busy));
    e.bubble  = e.stall || fls;
    e.md_busy = busy;
    e.cyc     = cyc;
    e.tag     = tag;
    sb_q.push_back(e);
    issue   = in.valid && !fls && !e.stall;
    stalled = e.stall;

    @(posedge clk);
    if (!rst_v) begin
      fl.delete();
      e_rs_use   = 1'b0;
      e_rt_use   = 1'b0;
      md_free_at = 0;
    end else begin
      foreach (fl[i]) if (fl[i].age + 1 <= NSTAGE) nq.push_back('{fl[i].age + 1, fl[i].wa, fl[i].rdy});
      fl = nq;
      if (issue && in.wr && in.wa != '0) fl.push_back('{1, in.wa, int'(in.rdy)});
      e_rs     = in.rs;
      e_rt     = in.rt;
      e_rs_use = issue && in.rs_use;
      e_rt_use = issue && in.rt_use;
      if (issue && in.md_start) md_free_at = cyc + 1 + (in.md_div ? DIV_LAT : MULT_LAT);
    end
    cyc++;
    #1;
  endtask

  // Hold an instruction in D until it issues, as the F/D register would.
  task automatic issue_i(input instr_t in, input string tag);
    logic st;
    int   n = 0;
    do begin
      step(in, 1'b0, 1'b1, tag, st);
      n++;
    end while (st && n < 40);
    checks++;
    if (st) begin
      errors++;
      $display("FAIL %s.issue_budget got=stalled_after_%0d required=issued", tag, n);
    end
  endtask

  task automatic nops(input int n, input string tag);
    logic st;
    for (int i = 0; i < n; i++) step(nop_i(), 1'b0, 1'b1, tag, st);
  endtask

  function automatic instr_t nop_i();
    instr_t r = '{default: '0};
    return r;
  endfunction

  function automatic instr_t alu_i(input int rd, input int rs, input int rt);
    instr_t r = nop_i();
    r.valid = 1'b1; r.rs = AW'(rs); r.rt = AW'(rt);
    r.rs_use = 1'b1; r.rt_use = 1'b1; r.rs_late = 1'b1; r.rt_late = 1'b1;
    r.wr = 1'b1; r.wa = AW'(rd); r.rdy = 2'd2;
    return r;
  endfunction

  function automatic instr_t ori_i(input int rt, input int rs);
    instr_t r = alu_i(rt, rs, 0);
    r.rt_use = 1'b0;
    return r;
  endfunction

  function automatic instr_t lw_i(input int rt, input int base);
    instr_t r = ori_i(rt, base);
    r.rdy = 2'd3;
    return r;
  endfunction

  function automatic instr_t beq_i(input int rs, input int rt);
    instr_t r = alu_i(0, rs, rt);
    r.wr = 1'b0; r.rs_late = 1'b0; r.rt_late = 1'b0;
    return r;
  endfunction

  function automatic instr_t jr_i(input int rs);
    instr_t r = beq_i(rs, 0);
    r.rt_use = 1'b0;
    return r;
  endfunction

  function automatic instr_t md_i(input logic is_div);
    instr_t r = alu_i(0, 1, 2);
    r.wr = 1'b0; r.md_start = 1'b1; r.md_div = is_div; r.md_use = 1'b1;
    return r;
  endfunction

  function automatic instr_t mf_i(input int rd);
    instr_t r = nop_i();
    r.valid = 1'b1; r.wr = 1'b1; r.wa = AW'(rd); r.rdy = 2'd3; r.md_use = 1'b1;
    return r;
  endfunction

  function automatic instr_t rnd_i();
    instr_t r;
    r.valid    = $urandom_range(0, 9) != 0;
    r.rs       = AW'($urandom_range(0, 7));
    r.rt       = AW'($urandom_range(0, 7));
    r.rs_use   = 1'($urandom_range(0, 1));
    r.rt_use   = 1'($urandom_range(0, 1));
    r.rs_late  = 1'($urandom_range(0, 1));
    r.rt_late  = 1'($urandom_range(0, 1));
    r.wr       = 1'($urandom_range(0, 1));
    r.wa       = AW'($urandom_range(0, 7));
    r.rdy      = FW'($urandom_range(2, NSTAGE));
    r.md_start = $urandom_range(0, 19) == 0;
    r.md_div   = 1'($urandom_range(0, 1));
    r.md_use   = r.md_start || ($urandom_range(0, 9) == 0);
    if (r.md_start) r.wr = 1'b0;
    return r;
  endfunction

  initial begin
    logic   st;
    instr_t cur;
    int     n;

    rst_n = 1'b0;
    d_valid = 1'b0; d_rs = '0; d_rt = '0; d_wa = '0;
    d_rs_use = 1'b0; d_rt_use = 1'b0; d_rs_late = 1'b0; d_rt_late = 1'b0;
    d_wr = 1'b0; d_rdy = '0; d_md_start = 1'b0; d_md_div = 1'b0; d_md_use = 1'b0;
    flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    nops(2, "reset");

    issue_i(alu_i(8, 1, 2), "alu_alu");
    issue_i(alu_i(9, 8, 1), "alu_alu");
    nops(4, "alu_alu");

    issue_i(lw_i(8, 3), "lw_alu");
    issue_i(alu_i(9, 8, 8), "lw_alu");
    nops(4, "lw_alu");

    issue_i(lw_i(4, 3), "lw_beq");
    issue_i(beq_i(4, 5), "lw_beq");
    nops(4, "lw_beq");

    issue_i(alu_i(7, 1, 2), "jr_young");
    issue_i(ori_i(7, 1), "jr_young");
    issue_i(jr_i(7), "jr_young");
    issue_i(alu_i(0, 1, 2), "zero_reg");
    issue_i(beq_i(0, 0), "zero_reg");
    nops(4, "zero_reg");

    issue_i(md_i(1'b1), "div_mflo");
    issue_i(mf_i(3), "div_mflo");
    nops(4, "div_mflo");

    issue_i(md_i(1'b0), "mult_mfhi");
    nops(2, "mult_mfhi");
    issue_i(mf_i(5), "mult_mfhi");
    nops(4, "mult_mfhi");

    issue_i(lw_i(8, 3), "flush");
    step(alu_i(9, 8, 8), 1'b1, 1'b1, "flush", st);
    issue_i(alu_i(10, 9, 8), "flush");
    nops(4, "flush");

    issue_i(md_i(1'b1), "reset_md");
    issue_i(lw_i(6, 1), "reset_md");
    step(beq_i(6, 6), 1'b0, 1'b0, "reset_md", st);
    nops(2, "reset_md");
    issue_i(mf_i(4), "reset_md");
    nops(4, "reset_md");

    cur = rnd_i();
    for (int i = 0; i < 800; i++) begin
      logic fls, rv;
      fls = $urandom_range(0, 19) == 0;
      rv  = $urandom_range(0, 99) != 0;
      step(cur, fls, rv, "rand", st);
      if (!st || fls || !rv) cur = rnd_i();
    end
    nops(3, "drain");

    n = 0;
    while (sb_q.size() > 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain.queue got=%0d_left required=0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_scoreboard.md
# pipe_scoreboard

Parametrised interlock and forwarding controller for the in-order MIPS pipeline. It tracks every in-flight register write in a per-stage scoreboard instead of re-decoding each stage's instruction word. From that it produces the decode stall, the D/E bubble and the D- and E-stage operand forward selects. It also owns a multiply/divide busy counter that interlocks mf/md instructions. It sits beside the decoder and takes pre-decoded fields for the instruction in D.

## Interface
Parameters:
- NSTAGE, 3: number of post-decode stages tracked (slot 1 = E … slot NSTAGE = last stage before register-file write); minimum 2.
- AW, 5: register address width.
- MULT_LAT, 5: cycles the mult/multu unit stays busy.
- DIV_LAT, 10: cycles the div/divu unit stays busy.
- FW, derived: $clog2(NSTAGE+1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- d_valid  in  1  D holds a real instruction.
- d_rs, d_rt  in  AW  source register numbers.
- d_rs_use, d_rt_use  in  1  source is read.
- d_rs_late, d_rt_late  in  1  0 = operand needed in D (branch/jr), 1 = needed in E.
- d_wr  in  1  instruction writes a GPR.
- d_wa  in  AW  destination register.
- d_rdy  in  FW  first slot (2..NSTAGE) whose pipeline register holds the result: 2 = ALU/jal, 3 = load/mf.
- d_md_start  in  1  D is mult/multu/div/divu.
- d_md_div  in  1  with d_md_start, selects DIV_LAT.
- d_md_use  in  1  D reads HI/LO or starts md (mfhi, mflo, mthi, mtlo, md ops).
- flush  in  1  kill the instruction in D (exception or redirect).
- stall  out  1  hold PC and F/D register.
- bubble_e  out  1  load a nop into D/E.
- fwd_rs_d, fwd_rt_d  out  FW  D-operand source: 0 = register file, k = slot k.
- fwd_rs_e, fwd_rt_e  out  FW  E-operand source: 0 = D/E register value, k = slot k (2..NSTAGE).
- md_busy  out  1  md counter non-zero.

## Operation
- Scoreboard: slots 1..NSTAGE, each holding {v, wa, rdy}. Slot 1 also holds the E instruction's {rs, rs_use, rt, rt_use}.
- Every cycle each slot k shifts into slot k+1; slot NSTAGE retires.
- Slot 1 is loaded from D when `d_valid && !stall && !flush`; otherwise it is loaded with v=0.
- Slots with wa == 0 are stored with v=0. Register $0 never matches, stalls or forwards.
- Match rule: a source matches slot k when `use && v_k && wa_k == src`. Only the youngest match (smallest k) is considered.
- D hazard for a source:
  - Early operand (late=0): stall if the youngest match has `rdy_k > k`; otherwise fwd = k.
  - Late operand (late=1): stall if `rdy_k > k+1`; D forward select is not used.
- E forward: compare the slot-1 sources against slots 2..NSTAGE; take the youngest match. The producer is always ready by construction.
- No match gives fwd = 0. The register file is not write-through, so slot NSTAGE is forwarded explicitly.
- MD counter:
  - Loaded with MULT_LAT or DIV_LAT when a d_md_start instruction issues into slot 1.
  - Otherwise decrements while non-zero.
  - md_busy is asserted while the counter is non-zero.
  - stall is forced when `d_md_use && md_busy`.
- stall = `d_valid && !flush && (any source hazard || md hazard)`.
- bubble_e = `stall || flush`.
- Reset: all slots v=0, counter 0. With d_valid=0, every output is 0 (stall, bubble_e, all fwd_*, md_busy).

## Timing
- stall, bubble_e and fwd_*_d are combinational from the D inputs and registered state. There are no zero-cycle paths from outputs back to inputs.
- fwd_*_e depend only on registered state, so they are valid from the start of the cycle.
- ALU→branch dependency: 1 stall cycle, then fwd = 2.
- Load→ALU dependency: 1 stall cycle, then fwd_e = 3.
- Load→branch dependency: 2 stall cycles, then fwd_d = 3.
- An md op issued at edge t raises md_busy after t. It falls exactly LAT cycles later.
- flush together with a hazard: flush wins. stall=0, bubble_e=1, and the scoreboard and counter do not load D.
- rst_n low mid-stall or mid-md: on the next edge all state clears and stall drops.
- Multiple matches: the youngest slot always wins over older writes to the same register.

## Test plan
- addu $8 → subu $9,$8,$1 back to back (NSTAGE=3) → no stall; fwd_rs_e=2 in the subu E cycle.
- lw $8 → addu $9,$8,$8 → exactly one cycle with stall=1 and bubble_e=1; then fwd_rs_e=fwd_rt_e=3.
- lw $4 → beq $4,$5 → stall for 2 cycles; then fwd_rs_d=3, fwd_rt_d=0.
- addu $7 then ori $7 then jr $7 → fwd_rs_d=2, taken from the younger ori; writes to $0 give fwd=0 and never stall.
- div (DIV_LAT=10) then mflo → md_busy high for 10 cycles; mflo is stalled until md_busy falls, then issues.
- lw $8 → addu using $8 with flush=1 in the hazard cycle → stall=0, bubble_e=1, slot 1 empty.
- Separately, rst_n=0 during the div → all outputs 0 on the next cycle.
